rgmii_ddr_tx_fmt: RTL and testbench

//  Transmit-side counterpart of the source-synchronous DDR input path: turns the MAC's GMII byte

---
 rtl/eth_rgmii_pkg.sv | 41 ++++
 rtl/rgmii_tx_clk_div.sv | 81 ++++++++
 rtl/rgmii_ddr_tx_fmt.sv | 117 +++++++++++
 tb/tb_rgmii_ddr_tx_fmt.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/eth_rgmii_pkg.sv
// eth_rgmii_pkg: shared RGMII definitions.
//   speed_e      : active link rate encoding (matches the 2-bit `speed` input)
//   DEF_DIV_*    : default 125 MHz cycles per nibble period at 100 / 10 Mb/s
//   tx_byte_t    : captured GMII byte with its control bits
//   tx_word_t    : one cycle's worth of ODDR q1/q2 values
//   decode_speed : maps the raw 2-bit speed input onto speed_e (2'b11 -> 1000)
package eth_rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  localparam int unsigned DEF_DIV_100 = 5;
  localparam int unsigned DEF_DIV_10  = 50;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } tx_byte_t;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       c1;
    logic       c2;
    logic       t1;
    logic       t2;
  } tx_word_t;

  function automatic speed_e decode_speed(input logic [1:0] s);
    case (s)
      2'b00:   return SPEED_10;
      2'b01:   return SPEED_100;
      default: return SPEED_1000;
    endcase
  endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// rgmii_tx_clk_div: byte-phase counter and forwarded-clock pattern generator.
//   clk, rst     : 125 MHz clock, synchronous active-high reset
//   act_speed    : speed in force for the current byte
//   next_speed   : speed in force for the next cycle (differs only at a boundary)
//   mac_ce       : byte-accept strobe (0 during rst and in the first cycle after it)
//   latch_en     : byte boundary; active speed may be re-latched here
//   nib_hi       : next cycle sends the upper nibble (10/100 only)
//   txc_q1_d/q2_d: next-cycle TXC values for the rising / falling ODDR edge
module rgmii_tx_clk_div
  import eth_rgmii_pkg::*;
#(
  parameter int unsigned DIV_100 = DEF_DIV_100,
  parameter int unsigned DIV_10  = DEF_DIV_10,
  parameter int unsigned CNT_W   = 7
) (
  input  logic   clk,
  input  logic   rst,
  input  speed_e act_speed,
  input  speed_e next_speed,
  output logic   mac_ce,
  output logic   latch_en,
  output logic   nib_hi,
  output logic   txc_q1_d,
  output logic   txc_q2_d
);

  localparam logic [CNT_W-1:0] N100    = CNT_W'(DIV_100);
  localparam logic [CNT_W-1:0] N10     = CNT_W'(DIV_10);
  localparam logic [CNT_W-1:0] LAST100 = CNT_W'(2 * DIV_100 - 1);
  localparam logic [CNT_W-1:0] LAST10  = CNT_W'(2 * DIV_10 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] last_cur, n_nxt, phase, half;

  always_comb begin
    last_cur = (act_speed == SPEED_10) ? LAST10 : LAST100;
    mac_ce   = 1'b0;
    if (!rst && !first_q) begin
      mac_ce = (act_speed == SPEED_1000) || (cnt_q == last_cur);
    end
    latch_en = mac_ce | first_q;
    first_d  = 1'b0;

    if (latch_en || act_speed == SPEED_1000) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pattern is computed for the count the next cycle will show, so the
    // registered outputs line up with cnt without an extra pipeline stage.
    n_nxt  = (next_speed == SPEED_10) ? N10 : N100;
    nib_hi = (cnt_d >= n_nxt);
    phase  = nib_hi ? (cnt_d - n_nxt) : cnt_d;
    half   = n_nxt >> 1;

    txc_q1_d = 1'b0;
    txc_q2_d = 1'b0;
    if (next_speed == SPEED_1000) begin
      txc_q1_d = 1'b1;
    end else if (phase < half) begin
      txc_q1_d = 1'b1;
      txc_q2_d = 1'b1;
    end else if (n_nxt[0] && phase == half) begin
      // odd N: the high time ends half-way through this cycle
      txc_q1_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/rgmii_ddr_tx_fmt.sv
// rgmii_ddr_tx_fmt: GMII byte stream to RGMII TX ODDR q1/q2 words at 1000/100/10 Mb/s.
//   clk, rst            : 125 MHz clock, synchronous active-high reset
//   speed[1:0]          : 10=1000, 01=100, 00=10, 11=1000; latched at byte boundaries only
//   gmii_txd/en/er      : MAC byte, sampled when mac_ce=1
//   mac_ce              : byte-accept strobe
//   txd_q1/q2           : TXD rising / falling edge values
//   tx_ctl_q1/q2        : TX_CTL rising (en) / falling (en^er) edge values
//   txc_q1/q2           : forwarded clock rising / falling edge values
//   frame_cnt[15:0]     : only with RGMII_TX_FRAME_CNT_EN; counts tx_en rising at accepted bytes
module rgmii_ddr_tx_fmt
  import eth_rgmii_pkg::*;
#(
  parameter int unsigned DIV_100 = DEF_DIV_100,
  parameter int unsigned DIV_10  = DEF_DIV_10,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       mac_ce,
  output logic [3:0] txd_q1,
  output logic [3:0] txd_q2,
  output logic       tx_ctl_q1,
  output logic       tx_ctl_q2,
  output logic       txc_q1,
  output logic       txc_q2
`ifdef RGMII_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  speed_e   spd_q, spd_d;
  tx_byte_t byte_q, byte_d;
  tx_word_t out_q, out_d;
  logic     latch_en, nib_hi, txc1_d, txc2_d;
  logic [3:0] nib;

  rgmii_tx_clk_div #(
    .DIV_100 (DIV_100),
    .DIV_10  (DIV_10),
    .CNT_W   (CNT_W)
  ) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .act_speed  (spd_q),
    .next_speed (spd_d),
    .mac_ce     (mac_ce),
    .latch_en   (latch_en),
    .nib_hi     (nib_hi),
    .txc_q1_d   (txc1_d),
    .txc_q2_d   (txc2_d)
  );

  always_comb begin
    spd_d  = latch_en ? decode_speed(speed) : spd_q;
    byte_d = mac_ce ? {gmii_txd, gmii_tx_en, gmii_tx_er} : byte_q;
    nib    = nib_hi ? byte_d.txd[7:4] : byte_d.txd[3:0];

    out_d.c1 = byte_d.en;
    out_d.c2 = byte_d.en ^ byte_d.er;
    out_d.t1 = txc1_d;
    out_d.t2 = txc2_d;
    if (spd_d == SPEED_1000) begin
      out_d.d1 = byte_d.txd[3:0];
      out_d.d2 = byte_d.txd[7:4];
    end else begin
      out_d.d1 = nib;
      out_d.d2 = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spd_q  <= SPEED_1000;
      byte_q <= '0;
      out_q  <= '0;
    end else begin
      spd_q  <= spd_d;
      byte_q <= byte_d;
      out_q  <= out_d;
    end
  end

  assign txd_q1    = out_q.d1;
  assign txd_q2    = out_q.d2;
  assign tx_ctl_q1 = out_q.c1;
  assign tx_ctl_q2 = out_q.c2;
  assign txc_q1    = out_q.t1;
  assign txc_q2    = out_q.t2;

`ifdef RGMII_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // byte_q.en is the tx_en of the previously accepted byte
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (mac_ce && gmii_tx_en && !byte_q.en) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_rgmii_ddr_tx_fmt.sv
// Randomized scoreboard bench for rgmii_ddr_tx_fmt. The model pushes, per accepted
// byte, the full list of per-cycle output words; the monitor pops one word per cycle.
module tb_rgmii_ddr_tx_fmt;

  typedef struct packed {
    logic       ce;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       c1;
    logic       c2;
    logic       t1;
    logic       t2;
  } exp_word_t;

  localparam int N100 = 5;
  localparam int N10  = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       mac_ce;
  logic [3:0] txd_q1, txd_q2;
  logic       tx_ctl_q1, tx_ctl_q2, txc_q1, txc_q2;
`ifdef RGMII_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  int unsigned fc_model = 0;
  logic        prev_en  = 1'b0;
`endif

  rgmii_ddr_tx_fmt #(
    .DIV_100 (N100),
    .DIV_10  (N10),
    .CNT_W   (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed      (speed),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .mac_ce     (mac_ce),
    .txd_q1     (txd_q1),
    .txd_q2     (txd_q2),
    .tx_ctl_q1  (tx_ctl_q1),
    .tx_ctl_q2  (tx_ctl_q2),
    .txc_q1     (txc_q1),
    .txc_q2     (txc_q2)
`ifdef RGMII_TX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_word_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit started   = 1'b0;
  bit after_rst = 1'b0;
  bit ended     = 1'b0;

  // Reference: one byte lasts 1 cycle at 1000, else 2N cycles with the low nibble
  // first. TXC is high for the first N half-cycles of each N-cycle nibble period.
  function automatic void push_segment(input logic [7:0] b, input logic e,
                                       input logic r, input logic [1:0] s);
    exp_word_t w;
    int n;
    if (s[1]) begin
      w = '{ce: 1'b1, d1: b[3:0], d2: b[7:4], c1: e, c2: e ^ r, t1: 1'b1, t2: 1'b0};
      exp_q.push_back(w);
    end else begin
      n = s[0] ? N100 : N10;
      for (int k = 0; k < 2 * n; k++) begin
        int p;
        p    = k % n;
        w.d1 = (k < n) ? b[3:0] : b[7:4];
        w.d2 = w.d1;
        w.c1 = e;
        w.c2 = e ^ r;
        w.t1 = (2 * p < n);
        w.t2 = (2 * p + 1 < n);
        w.ce = (k == 2 * n - 1);
        exp_q.push_back(w);
      end
    end
  endfunction

  // Model: reacts to each edge using the inputs the DUT samples at that edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      after_rst = 1'b1;
      started   = 1'b1;
`ifdef RGMII_TX_FRAME_CNT_EN
      fc_model = 0;
      prev_en  = 1'b0;
`endif
    end else if (after_rst) begin
      push_segment(8'h00, 1'b0, 1'b0, speed);
      after_rst = 1'b0;
    end else if (ended) begin
      push_segment(gmii_txd, gmii_tx_en, gmii_tx_er, speed);
`ifdef RGMII_TX_FRAME_CNT_EN
      if (gmii_tx_en && !prev_en) fc_model = (fc_model + 1) % 65536;
      prev_en = gmii_tx_en;
`endif
    end
  end

  // Monitor: one expected word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_word_t w, act;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        ended = 1'b0;
        $display("FAIL queue_underflow t=%0t", $time);
      end else begin
        w     = exp_q.pop_front();
        ended = w.ce;
        w.ce  = w.ce & ~rst;
        act   = '{ce: mac_ce, d1: txd_q1, d2: txd_q2, c1: tx_ctl_q1,
                  c2: tx_ctl_q2, t1: txc_q1, t2: txc_q2};
        if (act !== w) begin
          errors++;
          $display("FAIL outputs t=%0t actual ce=%b d=%h/%h ctl=%b%b txc=%b%b required ce=%b d=%h/%h ctl=%b%b txc=%b%b",
                   $time, act.ce, act.d1, act.d2, act.c1, act.c2, act.t1, act.t2,
                   w.ce, w.d1, w.d2, w.c1, w.c2, w.t1, w.t2);
        end
      end
`ifdef RGMII_TX_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 16'(fc_model)) begin
        errors++;
        $display("FAIL frame_cnt t=%0t actual=%0d required=%0d", $time, frame_cnt, fc_model);
      end
`endif
    end
  end

  task automatic run(input int unsigned cycles, input logic [1:0] spd,
                     input bit rand_spd, input int unsigned rst_permille);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      rst      = ($urandom_range(0, 999) < rst_permille);
      gmii_txd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) gmii_tx_en = ~gmii_tx_en;
      gmii_tx_er = ($urandom_range(0, 7) == 0);
      if (!rand_spd) speed = spd;
      else if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst        = 1'b1;
    speed      = 2'b10;
    gmii_txd   = 8'hA5;
    gmii_tx_en = 1'b1;
    gmii_tx_er = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run(150, 2'b10, 1'b0, 0);
    run(150, 2'b11, 1'b0, 0);
    run(300, 2'b01, 1'b0, 0);
    run(500, 2'b00, 1'b0, 0);
    run(3000, 2'b00, 1'b1, 2);
    run(1500, 2'b00, 1'b1, 6);
    run(200, 2'b01, 1'b0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
